i2c_slave_responder: RTL and testbench

//  Synthesizable I2C slave (responder) for the far end of the iicmb_m_wb master's bus.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_slave_responder.sv | 179 +++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C types and constants for the bus responder and its line front end.
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NAK = 1'b1;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw scl/sda and derives scl edges plus START/STOP conditions.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl;
  logic                   scl_q;
  logic                   sda_q;

  // No reset: the chains keep tracking the bus so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_raw};
    sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_raw};
    scl_q  <= scl_sr[SYNC_STAGES-1];
    sda_q  <= sda_sr[SYNC_STAGES-1];
  end

  assign scl       = scl_sr[SYNC_STAGES-1];
  assign sda       = sda_sr[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C responder: address match/ACK, write-byte strobe, read bytes from a valid/ready
// source with optional SCL stretching while read data is missing.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus ignored until START
// ADDR     | shifting in the address byte
// ADDR_ACK | pulling sda low for the address ACK bit
// WR_DATA  | shifting in a write byte
// WR_ACK   | pulling sda low for the data ACK bit
// RD_LOAD  | fetching the next read byte (stretching scl if enabled)
// RD_DATA  | driving read bits 7..0
// RD_ACK   | sampling master ACK/NAK
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h22,
  parameter int                        SYNC_STAGES = 2,
  parameter bit                        STRETCH_EN  = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
  output logic                      rx_valid_o,
  input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic                      start_o,
  output logic                      stop_o,
  output i2c_op_t                   rw_o,
  output logic                      busy_o,
  output logic                      nak_o
);

  localparam logic [3:0] LAST_BIT  = 4'(I2C_DATA_WIDTH - 1);
  localparam logic [3:0] BYTE_BITS = 4'(I2C_DATA_WIDTH);

  i2c_slv_state_t            state;
  logic [3:0]                bit_cnt;
  logic [I2C_DATA_WIDTH-1:0] shift;
  logic                      sda;
  logic                      scl_rise;
  logic                      scl_fall;
  logic                      start_det;
  logic                      stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk_i),
    .scl_raw   (scl_i),
    .sda_raw   (sda_i),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      scl_o      <= 1'b1;
      sda_o      <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      rw_o       <= I2C_WRITE;
      busy_o     <= 1'b0;
      nak_o      <= 1'b0;
    end else begin
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      nak_o      <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        start_o <= 1'b1;
        busy_o  <= 1'b0;
        sda_o   <= 1'b1;
        scl_o   <= 1'b1;
      end else if (stop_det) begin
        state  <= IDLE;
        stop_o <= 1'b1;
        busy_o <= 1'b0;
        sda_o  <= 1'b1;
        scl_o  <= 1'b1;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift   <= {shift[I2C_DATA_WIDTH-2:0], sda};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              // shift still holds the seven address bits; sda is the R/W bit
              if (shift[I2C_ADDR_WIDTH-1:0] == SLAVE_ADDR) begin
                rw_o   <= i2c_op_t'(sda);
                busy_o <= 1'b1;
                state  <= ADDR_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            // first fall starts the ACK bit, second fall ends it
            if (sda_o) begin
              sda_o <= I2C_ACK;
            end else begin
              sda_o   <= 1'b1;
              bit_cnt <= '0;
              state   <= (state == ADDR_ACK && rw_o == I2C_READ) ? RD_LOAD : WR_DATA;
            end
          end
          WR_DATA: if (scl_rise) begin
            shift   <= {shift[I2C_DATA_WIDTH-2:0], sda};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              rx_data_o  <= {shift[I2C_DATA_WIDTH-2:0], sda};
              rx_valid_o <= 1'b1;
              state      <= WR_ACK;
            end
          end
          RD_LOAD: begin
            if (tx_valid_i) begin
              shift      <= tx_data_i;
              sda_o      <= tx_data_i[I2C_DATA_WIDTH-1];
              tx_ready_o <= 1'b1;
              bit_cnt    <= '0;
              state      <= RD_DATA;
            end else if (STRETCH_EN) begin
              scl_o <= 1'b0;
            end else begin
              shift   <= '1;
              sda_o   <= 1'b1;
              bit_cnt <= '0;
              state   <= RD_DATA;
            end
          end
          RD_DATA: begin
            // a stretch ends one clock after bit 7 is already on sda
            if (!scl_o) scl_o <= 1'b1;
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == BYTE_BITS) begin
                sda_o <= 1'b1;
                state <= RD_ACK;
              end else begin
                shift <= {shift[I2C_DATA_WIDTH-2:0], 1'b0};
                sda_o <= shift[I2C_DATA_WIDTH-2];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_NAK) begin
                nak_o  <= 1'b1;
                busy_o <= 1'b0;
                state  <= IDLE;
              end
            end else if (scl_fall) begin
              state <= RD_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bit-level I2C master bench for i2c_slave_responder with scoreboarded rx/read data.
module tb_i2c_slave_responder;

  localparam int Q = 5;
  localparam int STRETCH_LIMIT = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_o, sda_o;
  logic       scl_bus, sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, start_p, stop_p, rw, busy, nak_p;

  int checks = 0;
  int failures = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_log[$];
  int src_idx = 0, rx_idx = 0;
  int stall_len = 0, stall_seen = 0;
  int start_cnt = 0, stop_cnt = 0, txr_cnt = 0, nak_cnt = 0, sda_low = 0, scl_low = 0;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .scl_i      (scl_bus),
    .sda_i      (sda_bus),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .start_o    (start_p),
    .stop_o     (stop_p),
    .rw_o       (rw),
    .busy_o     (busy),
    .nak_o      (nak_p)
  );

  // read-data source: presents src_q in order, optionally withholding data while scl is stretched
  always @(negedge clk) begin
    if (tx_ready && tx_valid) src_idx++;
    if (!scl_o && stall_seen < stall_len) stall_seen++;
    tx_valid = (src_idx < src_q.size()) && (stall_seen >= stall_len);
    tx_data  = (src_idx < src_q.size()) ? src_q[src_idx] : 8'h00;
  end

  always @(negedge clk) begin
    if (start_p) start_cnt++;
    if (stop_p) stop_cnt++;
    if (tx_ready) txr_cnt++;
    if (nak_p) nak_cnt++;
    if (!sda_o) sda_low++;
    if (!scl_o) scl_low++;
    if (rx_valid) rx_log.push_back(rx_data);
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release();
    int n = 0;
    scl_m = 1'b1;
    while (scl_bus !== 1'b1 && n < STRETCH_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= STRETCH_LIMIT) chk("scl_release_timeout", n, 0);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    r = sda_bus;
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, r);
      d = {d[6:0], r};
    end
    bit_xfer(ack, r);
  endtask

  task automatic drain_rx();
    while (rx_idx < rx_log.size()) begin
      if (exp_rx.size() == 0) chk("rx_extra", {24'd0, rx_log[rx_idx]}, 32'h100);
      else chk("rx_data", {24'd0, rx_log[rx_idx]}, {24'd0, exp_rx.pop_front()});
      rx_idx++;
    end
  endtask

  task automatic write_data(input logic [7:0] b, input string tag);
    logic ack;
    exp_rx.push_back(b);
    write_byte(b, ack);
    chk(tag, ack, 0);
    drain_rx();
  endtask

  task automatic read_check(input logic ack, input string tag);
    logic [7:0] d;
    read_byte(ack, d);
    chk(tag, d, exp_rd.pop_front());
  endtask

  initial begin
    logic ack;
    logic [7:0] d;
    int s0, s1, s2, s3, s4;

    wait_clk(6);
    chk("rst_scl_o", scl_o, 1);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {rx_valid, tx_ready, start_p, stop_p, nak_p}, 0);
    rst_n = 1'b1;
    wait_clk(6);

    // write 32 bytes
    s0 = start_cnt; s1 = stop_cnt;
    bus_start();
    write_byte(8'h44, ack);
    chk("t1_addr_ack", ack, 0);
    chk("t1_rw", rw, 0);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 32; i++) write_data(8'(i), $sformatf("t1_ack[%0d]", i));
    bus_stop();
    wait_clk(4);
    chk("t1_starts", start_cnt - s0, 1);
    chk("t1_stops", stop_cnt - s1, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_rx_count", rx_log.size(), 32);

    // read 32 bytes, NAK the last
    for (int i = 0; i < 32; i++) begin
      src_q.push_back(8'(8'h40 + i));
      exp_rd.push_back(8'(8'h40 + i));
    end
    s0 = txr_cnt; s1 = nak_cnt;
    bus_start();
    write_byte(8'h45, ack);
    chk("t2_addr_ack", ack, 0);
    chk("t2_rw", rw, 1);
    for (int i = 0; i < 32; i++) read_check(i == 31, $sformatf("t2_rd[%0d]", i));
    chk("t2_busy_after_nak", busy, 0);
    bus_stop();
    chk("t2_tx_ready", txr_cnt - s0, 32);
    chk("t2_nak", nak_cnt - s1, 1);

    // wrong address
    s0 = sda_low; s1 = rx_log.size();
    bus_start();
    write_byte(8'h46, ack);
    chk("t3_nak", ack, 1);
    chk("t3_busy", busy, 0);
    bus_stop();
    chk("t3_sda_low", sda_low - s0, 0);
    chk("t3_rx", rx_log.size() - s1, 0);

    // read with source withholding data for 500 clocks
    src_q.push_back(8'hA5); exp_rd.push_back(8'hA5);
    src_q.push_back(8'h3C); exp_rd.push_back(8'h3C);
    s0 = scl_low;
    stall_len = stall_seen + 500;
    bus_start();
    write_byte(8'h45, ack);
    chk("t4_addr_ack", ack, 0);
    read_check(1'b0, "t4_rd0");
    s1 = scl_low - s0;
    chk("t4_stretch_len", (s1 >= 500 && s1 <= 505), 1);
    read_check(1'b1, "t4_rd1");
    bus_stop();

    // write + repeated START + read, 64 times
    s0 = start_cnt; s1 = nak_cnt; s2 = txr_cnt;
    for (int i = 0; i < 64; i++) begin
      src_q.push_back(8'(8'h3F - i));
      exp_rd.push_back(8'(8'h3F - i));
      bus_start();
      write_byte(8'h44, ack);
      chk($sformatf("t5_waddr[%0d]", i), ack, 0);
      chk($sformatf("t5_rw_w[%0d]", i), rw, 0);
      write_data(8'(8'h40 + i), $sformatf("t5_wack[%0d]", i));
      bus_start();
      write_byte(8'h45, ack);
      chk($sformatf("t5_raddr[%0d]", i), ack, 0);
      chk($sformatf("t5_rw_r[%0d]", i), rw, 1);
      read_check(1'b1, $sformatf("t5_rd[%0d]", i));
      bus_stop();
    end
    chk("t5_starts", start_cnt - s0, 128);
    chk("t5_naks", nak_cnt - s1, 64);
    chk("t5_tx_ready", txr_cnt - s2, 64);

    // reset in the middle of a read byte
    src_q.push_back(8'h00);
    bus_start();
    write_byte(8'h45, ack);
    chk("t6_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, ack);
    chk("t6_pre_reset_sda", sda_o, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_reset_sda", sda_o, 1);
    chk("t6_reset_scl", scl_o, 1);
    chk("t6_reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, ack);
    bit_xfer(1'b1, ack);
    bus_stop();
    s0 = rx_log.size();
    bus_start();
    write_byte(8'h44, ack);
    chk("t6_post_addr_ack", ack, 0);
    write_data(8'h5A, "t6_post_wack");
    bus_stop();
    chk("t6_post_rx", rx_log.size() - s0, 1);

    wait_clk(4);
    drain_rx();
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("src_all_consumed", src_idx, src_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
